// File: rtl/cache_flush_ctrl.sv
// rtl/cache_flush_ctrl.sv - cache-level flush initiator: blocks core traffic, drains, broadcasts flush, collects bank completion
module cache_flush_ctrl #(
  parameter int NUM_REQS   = 4,
  parameter int NUM_BANKS  = 1,
  parameter int TAG_WIDTH  = 8,
  parameter int PEND_WIDTH = 8,
  localparam int IDX_WIDTH = (NUM_REQS > 1) ? $clog2(NUM_REQS) : 1
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [NUM_REQS-1:0]           core_req_valid,
  input  logic [NUM_REQS-1:0]           core_req_flush,
  input  logic [NUM_REQS*TAG_WIDTH-1:0] core_req_tag,
  output logic [NUM_REQS-1:0]           core_req_ready,
  output logic [NUM_REQS-1:0]           bank_req_valid,
  input  logic [NUM_REQS-1:0]           bank_req_ready,
  input  logic [NUM_REQS-1:0]           core_rsp_fire,
  output logic [NUM_BANKS-1:0]          flush_begin,
  input  logic [NUM_BANKS-1:0]          flush_end,
  output logic                          flush_rsp_valid,
  output logic [IDX_WIDTH-1:0]          flush_rsp_idx,
  output logic [TAG_WIDTH-1:0]          flush_rsp_tag,
  input  logic                          flush_rsp_ready
);

  localparam int CNT_WIDTH = $clog2(NUM_REQS + 1);
  localparam int EXT_WIDTH = PEND_WIDTH + 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_DRAIN,
    S_BEGIN,
    S_WAIT,
    S_RESP
  } state_e;

  state_e                  state_q, state_d;
  logic [PEND_WIDTH-1:0]   pend_q, pend_d;
  logic [NUM_BANKS-1:0]    done_q, done_d;
  logic [IDX_WIDTH-1:0]    idx_q, idx_d;
  logic [TAG_WIDTH-1:0]    tag_q, tag_d;

  logic [NUM_REQS-1:0]     flush_req;
  logic [NUM_REQS-1:0]     flush_onehot;
  logic                    flush_any;
  logic [IDX_WIDTH-1:0]    flush_sel;
  logic [TAG_WIDTH-1:0]    flush_tag;

  logic [CNT_WIDTH-1:0]    inc_cnt, dec_cnt;
  logic [EXT_WIDTH-1:0]    pend_ext, pend_diff;
  logic                    pend_under, pend_over;

  assign flush_req = core_req_valid & core_req_flush;

  // Lowest-index flush wins; higher ports stall and are served by later flushes.
  always_comb begin
    flush_any    = 1'b0;
    flush_sel    = '0;
    flush_tag    = '0;
    flush_onehot = '0;
    for (int i = NUM_REQS - 1; i >= 0; i--) begin
      if (flush_req[i]) begin
        flush_any    = 1'b1;
        flush_sel    = IDX_WIDTH'(i);
        flush_tag    = core_req_tag[i*TAG_WIDTH +: TAG_WIDTH];
        flush_onehot = NUM_REQS'(1) << i;
      end
    end
  end

  always_comb begin
    inc_cnt = '0;
    dec_cnt = '0;
    for (int i = 0; i < NUM_REQS; i++) begin
      inc_cnt = inc_cnt + CNT_WIDTH'(bank_req_valid[i] & bank_req_ready[i]);
      dec_cnt = dec_cnt + CNT_WIDTH'(core_rsp_fire[i]);
    end
  end

  // One guard bit so under/overflow is detectable rather than wrapping silently.
  assign pend_ext   = {1'b0, pend_q} + EXT_WIDTH'(inc_cnt);
  assign pend_diff  = pend_ext - EXT_WIDTH'(dec_cnt);
  assign pend_under = pend_ext < EXT_WIDTH'(dec_cnt);
  assign pend_over  = !pend_under && pend_diff[PEND_WIDTH];
  assign pend_d     = pend_diff[PEND_WIDTH-1:0];

  always_comb begin
    state_d         = state_q;
    idx_d           = idx_q;
    tag_d           = tag_q;
    done_d          = done_q;
    core_req_ready  = '0;
    bank_req_valid  = '0;
    flush_begin     = '0;
    flush_rsp_valid = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        bank_req_valid = core_req_valid & ~core_req_flush;
        core_req_ready = (bank_req_ready & ~flush_req) | flush_onehot;
        if (flush_any) begin
          idx_d   = flush_sel;
          tag_d   = flush_tag;
          state_d = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (pend_q == '0) begin
          state_d = S_BEGIN;
        end
      end
      S_BEGIN: begin
        flush_begin = '1;
        done_d      = '0;
        state_d     = S_WAIT;
      end
      S_WAIT: begin
        // Same-cycle pulses count, so a bank ending now can complete the set.
        done_d = done_q | flush_end;
        if (&done_d) begin
          state_d = S_RESP;
        end
      end
      S_RESP: begin
        flush_rsp_valid = 1'b1;
        if (flush_rsp_ready) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign flush_rsp_idx = idx_q;
  assign flush_rsp_tag = tag_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      pend_q  <= '0;
      done_q  <= '0;
      idx_q   <= '0;
      tag_q   <= '0;
    end else begin
      state_q <= state_d;
      pend_q  <= pend_d;
      done_q  <= done_d;
      idx_q   <= idx_d;
      tag_q   <= tag_d;
    end
  end

  assert property (@(posedge clk) disable iff (reset) !pend_under);
  assert property (@(posedge clk) disable iff (reset) !pend_over);

endmodule

// File: tb/tb_cache_flush_ctrl.sv
// tb/tb_cache_flush_ctrl.sv - directed and randomized check of cache_flush_ctrl against a timestamp-based flush model
module tb_cache_flush_ctrl;
  localparam int NR = 4;
  localparam int NB = 4;
  localparam int TW = 8;
  localparam int PW = 8;

  logic             clk = 1'b0;
  logic             reset;
  logic [NR-1:0]    core_req_valid, core_req_flush, core_req_ready;
  logic [NR*TW-1:0] core_req_tag;
  logic [NR-1:0]    bank_req_valid, bank_req_ready, core_rsp_fire;
  logic [NB-1:0]    flush_begin, flush_end;
  logic             flush_rsp_valid, flush_rsp_ready;
  logic [1:0]       flush_rsp_idx;
  logic [TW-1:0]    flush_rsp_tag;

  cache_flush_ctrl #(.NUM_REQS(NR), .NUM_BANKS(NB), .TAG_WIDTH(TW), .PEND_WIDTH(PW)) dut (
    .clk(clk), .reset(reset),
    .core_req_valid(core_req_valid), .core_req_flush(core_req_flush),
    .core_req_tag(core_req_tag), .core_req_ready(core_req_ready),
    .bank_req_valid(bank_req_valid), .bank_req_ready(bank_req_ready),
    .core_rsp_fire(core_rsp_fire),
    .flush_begin(flush_begin), .flush_end(flush_end),
    .flush_rsp_valid(flush_rsp_valid), .flush_rsp_idx(flush_rsp_idx),
    .flush_rsp_tag(flush_rsp_tag), .flush_rsp_ready(flush_rsp_ready)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Model: a flush is "busy" from acceptance until its response is taken;
  // m_tbeg is the cycle flush_begin must pulse (-1 while still draining).
  bit            m_busy, m_rsp;
  int            m_tbeg, m_idx, pend_m, cyc, acc_port;
  logic [NB-1:0] m_got;
  logic [TW-1:0] m_tag;
  bit            hold[NR];
  logic [TW-1:0] htag[NR];
  logic [NB-1:0] sched[8];
  logic [NR-1:0] fsched[16];

  function automatic int lowest_flush();
    for (int i = 0; i < NR; i++)
      if (core_req_valid[i] && core_req_flush[i]) return i;
    return -1;
  endfunction

  task automatic check_outputs();
    logic [NR-1:0] e_bv, e_rdy;
    logic [NB-1:0] e_fb;
    int sel;
    e_bv = '0;
    e_rdy = '0;
    if (!m_busy) begin
      sel = lowest_flush();
      for (int i = 0; i < NR; i++) begin
        e_bv[i]  = core_req_valid[i] & ~core_req_flush[i];
        e_rdy[i] = (core_req_valid[i] && core_req_flush[i]) ? (i == sel) : bank_req_ready[i];
      end
    end
    e_fb = (m_busy && m_tbeg == cyc) ? {NB{1'b1}} : {NB{1'b0}};
    check_eq("bank_req_valid", bank_req_valid, e_bv);
    check_eq("core_req_ready", core_req_ready, e_rdy);
    check_eq("flush_begin", flush_begin, e_fb);
    check_eq("flush_rsp_valid", flush_rsp_valid, m_rsp);
    if (m_rsp) begin
      check_eq("flush_rsp_idx", flush_rsp_idx, m_idx);
      check_eq("flush_rsp_tag", flush_rsp_tag, m_tag);
    end
  endtask

  task automatic update_model();
    int inc, dec, sel;
    inc = 0;
    dec = 0;
    sel = lowest_flush();
    acc_port = -1;
    for (int i = 0; i < NR; i++) begin
      if (!m_busy && core_req_valid[i] && !core_req_flush[i] && bank_req_ready[i]) inc++;
      if (core_rsp_fire[i]) dec++;
    end
    if (reset) begin
      m_busy = 0; m_rsp = 0; m_tbeg = -1; pend_m = 0;
    end else begin
      if (!m_busy) begin
        if (sel >= 0) begin
          m_busy = 1; m_idx = sel; m_tag = core_req_tag[sel*TW +: TW];
          m_tbeg = -1; acc_port = sel; hold[sel] = 0;
        end
      end else if (m_tbeg < 0) begin
        if (pend_m == 0) begin m_tbeg = cyc + 1; m_got = '0; end
      end else if (m_rsp) begin
        if (flush_rsp_ready) begin m_busy = 0; m_rsp = 0; end
      end else if (cyc > m_tbeg) begin
        m_got = m_got | flush_end;
        if (&m_got) m_rsp = 1;
      end
      pend_m = pend_m + inc - dec;
    end
    cyc++;
  endtask

  task automatic tick();
    @(negedge clk);
    check_outputs();
    @(posedge clk);
    update_model();
    #1;
  endtask

  task automatic clear_sched();
    for (int i = 0; i < 8; i++) sched[i] = '0;
    for (int i = 0; i < 16; i++) fsched[i] = '0;
  endtask

  task automatic run_flush(input int limit);
    int k, rc;
    k = 0;
    rc = 0;
    while (m_busy && k < limit) begin
      flush_end = '0;
      if (m_tbeg >= 0 && cyc > m_tbeg && (cyc - m_tbeg - 1) < 8) flush_end = sched[cyc - m_tbeg - 1];
      core_rsp_fire = (k < 16) ? fsched[k] : '0;
      if (m_rsp) rc++;
      flush_rsp_ready = (rc >= 2);
      tick();
      if (acc_port >= 0) begin
        core_req_valid[acc_port] = 1'b0;
        core_req_flush[acc_port] = 1'b0;
      end
      k++;
    end
    flush_end = '0;
    core_rsp_fire = '0;
    flush_rsp_ready = 1'b0;
    check_eq("flush_completes", m_busy, 0);
  endtask

  task automatic start_flush(input int port, input logic [TW-1:0] tag);
    core_req_valid[port] = 1'b1;
    core_req_flush[port] = 1'b1;
    core_req_tag[port*TW +: TW] = tag;
  endtask

  task automatic random_drive();
    int budget;
    for (int i = 0; i < NR; i++) begin
      if (!hold[i] && $urandom_range(15) == 0) begin
        hold[i] = 1;
        htag[i] = TW'($urandom);
      end
      if (hold[i]) begin
        core_req_valid[i] = 1'b1;
        core_req_flush[i] = 1'b1;
        core_req_tag[i*TW +: TW] = htag[i];
      end else begin
        core_req_valid[i] = ($urandom_range(1) == 1) && (pend_m < 200);
        core_req_flush[i] = 1'b0;
        core_req_tag[i*TW +: TW] = TW'($urandom);
      end
    end
    bank_req_ready = NR'($urandom);
    budget = pend_m;
    core_rsp_fire = '0;
    for (int i = 0; i < NR; i++)
      if (budget > 0 && $urandom_range(2) == 0) begin
        core_rsp_fire[i] = 1'b1;
        budget--;
      end
    flush_end = ($urandom_range(2) == 0) ? NB'($urandom) : '0;
    flush_rsp_ready = ($urandom_range(1) == 1);
    reset = m_busy && m_tbeg >= 0 && cyc > m_tbeg && !m_rsp && ($urandom_range(19) == 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int guard;
    reset = 1'b1;
    core_req_valid = '0; core_req_flush = '0; core_req_tag = '0;
    bank_req_ready = '0; core_rsp_fire = '0; flush_end = '0; flush_rsp_ready = 1'b0;
    m_busy = 0; m_rsp = 0; m_tbeg = -1; m_got = '0; m_idx = 0; m_tag = '0;
    pend_m = 0; cyc = 0; acc_port = -1;
    for (int i = 0; i < NR; i++) begin hold[i] = 0; htag[i] = '0; end
    clear_sched();
    @(posedge clk); #1;
    tick();
    check_eq("reset_rsp_idx", flush_rsp_idx, 0);
    check_eq("reset_rsp_tag", flush_rsp_tag, 0);
    reset = 1'b0;

    // Idle pass-through on port 2, then return every response.
    bank_req_ready = '1;
    core_req_valid = 4'b0100;
    repeat (3) tick();
    core_req_valid = '0;
    core_rsp_fire = 4'b0100;
    repeat (3) tick();
    core_rsp_fire = '0;

    // Basic flush from port 1, banks end two cycles after begin.
    clear_sched();
    sched[1] = '1;
    start_flush(1, 8'h5A);
    tick();
    core_req_valid = '0; core_req_flush = '0;
    run_flush(40);

    // Drain: three outstanding, responses at +4, +6, +9 after accept.
    core_req_valid = 4'b0001;
    repeat (3) tick();
    core_req_valid = '0;
    clear_sched();
    sched[0] = '1;
    fsched[3] = 4'b0001; fsched[5] = 4'b0001; fsched[8] = 4'b0001;
    start_flush(3, 8'hC3);
    tick();
    core_req_valid = '0; core_req_flush = '0;
    run_flush(40);

    // Out-of-order and same-cycle completion with a duplicate bank 3 pulse.
    clear_sched();
    sched[0] = 4'b1000; sched[2] = 4'b0101; sched[3] = 4'b1000; sched[4] = 4'b0010;
    start_flush(2, 8'h17);
    tick();
    core_req_valid = '0; core_req_flush = '0;
    run_flush(40);

    // Contention: flushes on 0 and 3, normal request on 2.
    clear_sched();
    sched[0] = '1;
    fsched[2] = 4'b0100;
    core_req_valid = 4'b1101; core_req_flush = 4'b1001;
    core_req_tag = {8'hD3, 8'h22, 8'h11, 8'hA0};
    tick();
    core_req_valid = 4'b1000; core_req_flush = 4'b1000;
    run_flush(40);
    tick();
    core_req_valid = '0; core_req_flush = '0;
    clear_sched();
    sched[0] = '1;
    run_flush(40);

    // Reset during WAIT aborts silently; stray flush_end afterwards is ignored.
    clear_sched();
    start_flush(0, 8'h99);
    tick();
    core_req_valid = '0; core_req_flush = '0;
    guard = 0;
    while (!(m_tbeg >= 0 && cyc > m_tbeg + 1) && guard < 20) begin tick(); guard++; end
    check_eq("reached_wait", guard < 20, 1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    flush_end = '1;
    tick();
    flush_end = '0;
    repeat (3) tick();
    check_eq("no_rsp_after_reset", flush_rsp_valid, 0);

    // Randomized traffic, flushes, completions and occasional reset in WAIT.
    for (int n = 0; n < 3000; n++) begin
      random_drive();
      tick();
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
